// File: rtl/dig_ctrl_pkg.sv
// Shared types for the digital control code sequencer.
package dig_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_FREE     = 2'd0,
        MODE_SINGLE   = 2'd1,
        MODE_TRIANGLE = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/reset_sync.sv
// Active-high reset synchroniser: asserts asynchronously, releases after two clock edges.
module reset_sync (
    input  logic clk,
    input  logic rst_in,
    output logic rst_out
);

    logic [1:0] sync_d, sync_q;

    always_comb begin
        sync_d = {sync_q[0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_out = sync_q[1];

endmodule

// File: rtl/dig_ctrl_sweep.sv
// Code sequencer for analog trim/DAC inputs: free-run, single sweep, triangle and hold modes
// with per-code dwell, change strobe and done flag.
module dig_ctrl_sweep
    import dig_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   start_code,
    input  logic [WIDTH-1:0]   stop_code,
    input  logic [WIDTH-1:0]   step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [WIDTH-1:0]   b,
    output logic               code_stb,
    output logic               done
);

    logic rst_s;

    reset_sync u_reset_sync (
        .clk     (clk),
        .rst_in  (reset),
        .rst_out (rst_s)
    );

    state_t               state_d, state_q;
    mode_t                mode_d, mode_q;
    logic [WIDTH-1:0]     b_d, b_q;
    logic [WIDTH-1:0]     first_d, first_q;
    logic [WIDTH-1:0]     last_d, last_q;
    logic [WIDTH-1:0]     step_d, step_q;
    logic [DWELL_W-1:0]   dwell_d, dwell_q;
    logic [DWELL_W-1:0]   cnt_d, cnt_q;
    logic                 up_d, up_q;
    logic                 fwd_d, fwd_q;
    logic                 stb_d, stb_q;
    logic                 done_d, done_q;
    logic                 tri_fwd;

    // One step from cur toward target, clamped so the target is never passed.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] stp,
                                                     input logic             up,
                                                     input logic [WIDTH-1:0] target);
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] res;
        if (up) begin
            sum = {1'b0, cur} + {1'b0, stp};
            res = (sum >= {1'b0, target}) ? target : sum[WIDTH-1:0];
        end else begin
            sum = {1'b0, cur} - {1'b0, stp};
            res = (sum[WIDTH] || sum <= {1'b0, target}) ? target : sum[WIDTH-1:0];
        end
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        b_d     = b_q;
        first_d = first_q;
        last_d  = last_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        up_d    = up_q;
        fwd_d   = fwd_q;
        stb_d   = 1'b0;
        done_d  = done_q;
        tri_fwd = fwd_q;

        if (start) begin
            state_d = ST_RUN;
            mode_d  = mode_t'(mode);
            b_d     = start_code;
            first_d = start_code;
            last_d  = stop_code;
            step_d  = (step == '0) ? WIDTH'(1) : step;
            dwell_d = dwell;
            cnt_d   = '0;
            up_d    = (start_code <= stop_code);
            fwd_d   = 1'b1;
            stb_d   = 1'b1;
            done_d  = 1'b0;
        end else if (state_q == ST_RUN && en) begin
            if (cnt_q != dwell_q) begin
                cnt_d = cnt_q + DWELL_W'(1);
            end else begin
                cnt_d = '0;
                case (mode_q)
                    MODE_FREE: b_d = b_q + step_q;
                    MODE_SINGLE: begin
                        if (b_q == last_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            b_d = step_toward(b_q, step_q, up_q, last_q);
                        end
                    end
                    MODE_TRIANGLE: begin
                        // Turn around at whichever end the current leg is heading for.
                        if (b_q == (fwd_q ? last_q : first_q)) begin
                            tri_fwd = ~fwd_q;
                        end
                        fwd_d = tri_fwd;
                        b_d   = step_toward(b_q, step_q, tri_fwd ? up_q : ~up_q,
                                            tri_fwd ? last_q : first_q);
                    end
                    default: ;
                endcase
                stb_d = (b_d != b_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_FREE;
            b_q     <= '0;
            first_q <= '0;
            last_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            up_q    <= 1'b1;
            fwd_q   <= 1'b1;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            b_q     <= b_d;
            first_q <= first_d;
            last_q  <= last_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            up_q    <= up_d;
            fwd_q   <= fwd_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
        end
    end

    assign b        = b_q;
    assign code_stb = stb_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dig_ctrl_sweep.sv
// Scoreboard bench for dig_ctrl_sweep: per-cycle expectations queued at drive time.
module tb_dig_ctrl_sweep;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [4:0] start_code = '0;
    logic [4:0] stop_code = '0;
    logic [4:0] step = '0;
    logic [7:0] dwell = '0;
    logic [4:0] b;
    logic       code_stb;
    logic       done;

    typedef struct packed {
        logic [4:0] b;
        logic       stb;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    logic [4:0] prev_b = '0;
    int         n_tests = 0;
    int         n_fail = 0;

    dig_ctrl_sweep #(
        .WIDTH   (5),
        .DWELL_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .en         (en),
        .mode       (mode),
        .start_code (start_code),
        .stop_code  (stop_code),
        .step       (step),
        .dwell      (dwell),
        .b          (b),
        .code_stb   (code_stb),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle and queue what the outputs must be after its rising edge.
    task automatic push_cyc(input logic st, input logic e, input logic [4:0] eb, input logic ed);
        exp_t x;
        @(negedge clk);
        #1;
        start  = st;
        en     = e;
        x.b    = eb;
        x.stb  = st || (eb != prev_b);
        x.done = ed;
        prev_b = eb;
        exp_q.push_back(x);
    endtask

    task automatic load(input logic [1:0] m, input logic [4:0] sc, input logic [4:0] ec,
                        input logic [4:0] st, input logic [7:0] dw);
        mode       = m;
        start_code = sc;
        stop_code  = ec;
        step       = st;
        dwell      = dw;
        push_cyc(1'b1, 1'b1, sc, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check_val("b", {27'd0, b}, {27'd0, cur.b});
            check_val("code_stb", {31'd0, code_stb}, {31'd0, cur.stb});
            check_val("done", {31'd0, done}, {31'd0, cur.done});
        end
    end

    initial begin
        int t2[7];
        int t3[4];
        int t4[8];
        t2 = '{3, 6, 6, 9, 9, 10, 10};
        t3 = '{16, 12, 8, 5};
        t4 = '{4, 6, 4, 2, 4, 6, 4, 2};

        @(negedge clk);
        check_val("rst_b", {27'd0, b}, 32'd0);
        check_val("rst_stb", {31'd0, code_stb}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        #1 reset = 1'b0;
        prev_b = '0;
        repeat (4) push_cyc(1'b0, 1'b1, 5'd0, 1'b0);

        // FREE, wraps 31 -> 0
        load(2'd0, 5'd0, 5'd9, 5'd1, 8'd0);
        for (int i = 1; i <= 34; i++) push_cyc(1'b0, 1'b1, 5'(i), 1'b0);

        // SINGLE up with clamp at stop
        load(2'd1, 5'd3, 5'd10, 5'd3, 8'd1);
        foreach (t2[i]) push_cyc(1'b0, 1'b1, 5'(t2[i]), 1'b0);
        repeat (3) push_cyc(1'b0, 1'b1, 5'd10, 1'b1);

        // SINGLE down, started from DONE
        load(2'd1, 5'd20, 5'd5, 5'd4, 8'd0);
        foreach (t3[i]) push_cyc(1'b0, 1'b1, 5'(t3[i]), 1'b0);
        repeat (3) push_cyc(1'b0, 1'b1, 5'd5, 1'b1);

        // TRIANGLE; a config change without start must be ignored
        load(2'd2, 5'd2, 5'd6, 5'd2, 8'd0);
        foreach (t4[i]) begin
            if (i == 3) begin
                stop_code = 5'd20;
                mode      = 2'd0;
            end
            push_cyc(1'b0, 1'b1, 5'(t4[i]), 1'b0);
        end

        // TRIANGLE with equal ends holds without strobes
        load(2'd2, 5'd9, 5'd9, 5'd2, 8'd0);
        repeat (3) push_cyc(1'b0, 1'b1, 5'd9, 1'b0);

        // SINGLE 0->31 dwell 3 with a pause mid-dwell
        load(2'd1, 5'd0, 5'd31, 5'd1, 8'd3);
        repeat (2) push_cyc(1'b0, 1'b1, 5'd0, 1'b0);
        repeat (5) push_cyc(1'b0, 1'b0, 5'd0, 1'b0);
        push_cyc(1'b0, 1'b1, 5'd0, 1'b0);
        repeat (4) push_cyc(1'b0, 1'b1, 5'd1, 1'b0);
        push_cyc(1'b0, 1'b1, 5'd2, 1'b0);
        start_code = 5'd7;
        push_cyc(1'b1, 1'b1, 5'd7, 1'b0);
        repeat (3) push_cyc(1'b0, 1'b1, 5'd7, 1'b0);

        // Asynchronous reset mid-run
        @(negedge clk);
        #1;
        start = 1'b0;
        reset = 1'b1;
        #1;
        check_val("async_rst_b", {27'd0, b}, 32'd0);
        check_val("async_rst_stb", {31'd0, code_stb}, 32'd0);
        check_val("async_rst_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        prev_b = '0;
        repeat (4) push_cyc(1'b0, 1'b1, 5'd0, 1'b0);

        // HOLD: one strobe on load only
        load(2'd3, 5'd17, 5'd3, 5'd1, 8'd0);
        repeat (4) push_cyc(1'b0, 1'b1, 5'd17, 1'b0);

        // FREE with step 0 behaves as step 1
        load(2'd0, 5'd30, 5'd0, 5'd0, 8'd0);
        push_cyc(1'b0, 1'b1, 5'd31, 1'b0);
        push_cyc(1'b0, 1'b1, 5'd0, 1'b0);
        push_cyc(1'b0, 1'b1, 5'd1, 1'b0);

        @(negedge clk);
        #1;
        check_val("drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
